// File: rtl/demux_pkg.sv
// demux_pkg: shared sizes and FSM state encoding for the 1-to-4 stream router
package demux_pkg;
  localparam int NUM_OUT = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;
endpackage

// File: rtl/demux_1x4_route_ctrl_demux.sv
// demux_1x4: steers d onto one of y0..y3 selected by {s1,s0}
// Ports: d (data in), s1/s0 (select), y0..y3 (one-hot outputs, all 0 when d=0)
module demux_1x4
  import demux_pkg::*;
(
  input  logic d,
  input  logic s1,
  input  logic s0,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);
  assign y0 = d & ~s1 & ~s0;
  assign y1 = d & ~s1 &  s0;
  assign y2 = d &  s1 & ~s0;
  assign y3 = d &  s1 &  s0;
endmodule

// File: rtl/demux_1x4_route_ctrl.sv
// demux_1x4_route_ctrl: single-entry stream router feeding four consumers over a shared bus
// Ports: clk, rst_n (sync active-low); in_valid/in_ready/in_data/in_dest (upstream beat);
//   out_valid[4] one-hot, out_ready[4], out_data (shared bus); s1/s0 registered selects;
//   busy (beat held); drop (pulse when a stalled beat is discarded).
// Build option: define DEMUX_TIMEOUT_EN to discard a beat stalled for TIMEOUT cycles.
module demux_1x4_route_ctrl
  import demux_pkg::*;
#(
  parameter int DW = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic [SEL_W-1:0]   in_dest,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [DW-1:0]      out_data,
  output logic               s1,
  output logic               s0,
  output logic               busy,
  output logic               drop
);
  logic              r_state;
  logic              w_next;
  logic [DW-1:0]     r_data;
  logic              r_s1;
  logic              r_s0;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_acc;
  logic              w_cap;
  logic              w_drop;
  logic [NUM_OUT-1:0] w_valid;

  demux_1x4 u_demux (
    .d  (r_state == ST_SEND),
    .s1 (r_s1),
    .s0 (r_s0),
    .y0 (w_valid[0]),
    .y1 (w_valid[1]),
    .y2 (w_valid[2]),
    .y3 (w_valid[3])
  );

  // w_valid is empty outside SEND, so this also masks non-selected readies
  assign w_acc = |(w_valid & out_ready);
  assign w_cap = in_valid & in_ready;

`ifdef DEMUX_TIMEOUT_EN
  // an acceptance in the timeout cycle wins over the drop
  assign w_drop = (r_state == ST_SEND) & ~w_acc & (r_cnt >= CNT_W'(TIMEOUT));
`else
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = w_cap ? ST_SEND
           : (r_state == ST_IDLE || w_acc || w_drop) ? ST_IDLE
           : ST_SEND;
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE) | w_acc;
    busy      = (r_state == ST_SEND);
    drop      = w_drop;
    out_valid = w_valid;
    out_data  = r_data;
    s1        = r_s1;
    s0        = r_s0;
  end

  // capture register holds its value in IDLE; stall counter saturates at TIMEOUT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
      r_s1   <= 1'b0;
      r_s0   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_cap) begin
      r_data       <= in_data;
      {r_s1, r_s0} <= in_dest;
      r_cnt        <= '0;
    end else if (r_state == ST_SEND && !w_acc && r_cnt < CNT_W'(TIMEOUT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_demux_1x4_route_ctrl.sv
// tb_demux_1x4_route_ctrl: directed and randomized checks of the router against a slot model
module tb_demux_1x4_route_ctrl;
`ifdef DEMUX_TIMEOUT_EN
  localparam int TMO = 4;
  localparam bit TO_EN = 1'b1;
  localparam int STALL = 4;
`else
  localparam int TMO = 15;
  localparam bit TO_EN = 1'b0;
  localparam int STALL = 5;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [1:0] in_dest = '0;
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;
  logic [7:0] out_data;
  logic       s1, s0, busy, drop;
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit m_held = 1'b0;
  logic [7:0] m_data = '0;
  logic [1:0] m_dest = '0;
  int m_stall = 0;

  always #5 clk = ~clk;

  demux_1x4_route_ctrl #(.DW(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .s1(s1), .s0(s0), .busy(busy), .drop(drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // the router as a one-entry slot: full/empty, contents, and how long it has waited
  always @(posedge clk) begin
    bit acc, dr;
    if (!rst_n) begin
      m_held = 1'b0; m_data = '0; m_dest = '0; m_stall = 0;
    end else begin
      acc = m_held && out_ready[m_dest];
      dr = TO_EN && m_held && !acc && m_stall >= TMO;
      if (in_valid && (!m_held || acc)) begin
        m_held = 1'b1; m_data = in_data; m_dest = in_dest; m_stall = 0;
      end else if (acc || dr) m_held = 1'b0;
      else if (m_held) m_stall++;
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) if (chk_en) begin
    bit acc;
    acc = m_held && out_ready[m_dest];
    check("m_out_valid", 32'(out_valid), m_held ? (32'd1 << m_dest) : 32'd0);
    check("m_in_ready", 32'(in_ready), 32'(!m_held || acc));
    check("m_out_data", 32'(out_data), 32'(m_data));
    check("m_sel", 32'({s1, s0}), 32'(m_dest));
    check("m_busy", 32'(busy), 32'(m_held));
    check("m_drop", 32'(drop), 32'(TO_EN && m_held && !acc && m_stall >= TMO));
  end

  initial begin
    int ndrop;
    rst_n = 1'b0; in_valid = 1'b1; in_dest = 2'd3; in_data = 8'h77; out_ready = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_sel", 32'({s1, s0}), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    tick();
    rst_n = 1'b1; in_valid = 1'b1; in_data = 8'hA5; in_dest = 2'd2; out_ready = 4'b1111;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("single_valid", 32'(out_valid), 32'h4);
    check("single_data", 32'(out_data), 32'hA5);
    check("single_sel", 32'({s1, s0}), 32'h2);
    tick();
    @(negedge clk);
    check("single_idle", 32'(busy), 32'h0);
    check("single_hold_data", 32'(out_data), 32'hA5);
    tick();
    in_valid = 1'b1; in_dest = 2'd0; in_data = 8'h10;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) begin
        in_dest = 2'(i + 1); in_data = 8'(8'h11 + i);
      end else in_valid = 1'b0;
      @(negedge clk);
      check("b2b_valid", 32'(out_valid), 32'd1 << i);
      check("b2b_ready", 32'(in_ready), 32'h1);
      check("b2b_data", 32'(out_data), 32'h10 + 32'(i));
    end
    tick();
    in_valid = 1'b1; in_dest = 2'd1; in_data = 8'h5A; out_ready = 4'b0000;
    tick();
    in_valid = 1'b0; in_dest = 2'd3; out_ready = 4'b0001;
    for (int k = 0; k < STALL; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'h2);
      check("bp_ready", 32'(in_ready), 32'h0);
      check("bp_data", 32'(out_data), 32'h5A);
      tick();
    end
    out_ready = 4'b0010;
    @(negedge clk);
    check("bp_release", 32'(in_ready), 32'h1);
    tick();
    @(negedge clk);
    check("bp_idle", 32'(out_valid), 32'h0);
    tick();
    in_valid = 1'b1; in_dest = 2'd3; in_data = 8'hC3; out_ready = 4'b0000;
    tick();
    in_valid = 1'b0;
`ifdef DEMUX_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("to_wait_drop", 32'(drop), 32'h0);
      check("to_wait_valid", 32'(out_valid), 32'h8);
      tick();
    end
    @(negedge clk);
    check("to_drop", 32'(drop), 32'h1);
    check("to_drop_ready", 32'(in_ready), 32'h0);
    tick();
    @(negedge clk);
    check("to_after_valid", 32'(out_valid), 32'h0);
    check("to_after_ready", 32'(in_ready), 32'h1);
    check("to_after_drop", 32'(drop), 32'h0);
`else
    ndrop = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (drop) ndrop++;
      tick();
    end
    @(negedge clk);
    check("hold_valid", 32'(out_valid), 32'h8);
    check("hold_busy", 32'(busy), 32'h1);
    check("hold_no_drop", 32'(ndrop), 32'h0);
    out_ready = 4'b1000;
    tick();
`endif
    tick();
    in_valid = 1'b1; in_dest = 2'd2; in_data = 8'h66; out_ready = 4'b0000;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_hold", 32'(out_valid), 32'h4);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_drop", 32'(drop), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    tick();
    in_valid = 1'b1; in_dest = 2'd1; in_data = 8'h99; out_ready = 4'b1111;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'h2);
    check("post_rst_data", 32'(out_data), 32'h99);
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n = ($urandom_range(0, 199) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data = 8'($urandom);
      in_dest = 2'($urandom);
      out_ready = ((i / 300) % 2 == 0) ? 4'($urandom)
                : (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
    end
    tick();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
